// File: rtl/uart_rx.sv
// uart_rx: UART receive path; 2-FF synchronized RX, mid-bit sampling, RXRDY held until CLR.
// Optional break detection with idle re-arm is built when UART_RX_BREAK_EN is defined.
module uart_rx #(
  parameter int DIV_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic [3:0] BAUD,
  input  logic       CLR,
  output logic [7:0] RX_DATA,
  output logic       RXRDY,
  output logic       PERR,
  output logic       FERR,
  output logic       OVF,
  output logic       BRK
);
  // state  | meaning
  // IDLE   | waiting for a low level on rxs
  // START  | half-bit wait, start bit re-checked
  // DATA   | sampling data bits at mid-bit
  // PARITY | sampling parity bit
  // STOP   | sampling stop bit, then completion
  // REARM  | after a break, wait for one full bit of idle line
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, REARM} state_t;

  state_t      state, state_n;
  logic        rx_meta, rxs;
  logic [18:0] base_cnt, sel_cnt, bit_len, timer;
  logic        tc, load_half, load_full, brk_now;
  logic [3:0]  nbit, last_bit;
  logic [7:0]  shreg, data_w, pend_data;
  logic        par_bit, eight_q, pen_q, ohel_q;
  logic        done, pend_perr, pend_ferr, pend_brk;
`ifdef UART_RX_BREAK_EN
  logic        zero_run;
`endif

  always_comb begin
    case (BAUD)
      4'd0:    base_cnt = 19'd333333;
      4'd1:    base_cnt = 19'd83333;
      4'd2:    base_cnt = 19'd41667;
      4'd3:    base_cnt = 19'd20833;
      4'd4:    base_cnt = 19'd10417;
      4'd5:    base_cnt = 19'd5208;
      4'd6:    base_cnt = 19'd2604;
      4'd7:    base_cnt = 19'd1736;
      4'd8:    base_cnt = 19'd868;
      4'd9:    base_cnt = 19'd434;
      4'd10:   base_cnt = 19'd217;
      default: base_cnt = 19'd109;
    endcase
  end

  // Floor of 2 keeps the half-bit load non-zero for aggressive DIV_SHIFT values.
  always_comb begin
    sel_cnt = base_cnt >> DIV_SHIFT;
    if (sel_cnt < 19'd2) sel_cnt = 19'd2;
  end

  assign tc       = (timer == 19'd0);
  assign last_bit = eight_q ? 4'd7 : 4'd6;
  assign data_w   = eight_q ? shreg : {1'b0, shreg[7:1]};
`ifdef UART_RX_BREAK_EN
  assign brk_now  = zero_run & ~rxs;
`else
  assign brk_now  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    load_half = 1'b0;
    load_full = 1'b0;
    case (state)
      IDLE: if (!rxs) begin
        state_n   = START;
        load_half = 1'b1;
      end
      START: if (tc) begin
        if (rxs) state_n = IDLE;
        else begin
          state_n   = DATA;
          load_full = 1'b1;
        end
      end
      DATA: if (tc) begin
        load_full = 1'b1;
        if (nbit == last_bit) state_n = pen_q ? PARITY : STOP;
      end
      PARITY: if (tc) begin
        load_full = 1'b1;
        state_n   = STOP;
      end
      STOP: if (tc) begin
        if (brk_now) begin
          state_n   = REARM;
          load_full = 1'b1;
        end else state_n = IDLE;
      end
      REARM: begin
        if (!rxs)   load_full = 1'b1;
        else if (tc) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      timer     <= '0;
      bit_len   <= '0;
      nbit      <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      eight_q   <= 1'b0;
      pen_q     <= 1'b0;
      ohel_q    <= 1'b0;
      done      <= 1'b0;
      pend_data <= '0;
      pend_perr <= 1'b0;
      pend_ferr <= 1'b0;
      pend_brk  <= 1'b0;
`ifdef UART_RX_BREAK_EN
      zero_run  <= 1'b0;
`endif
    end else begin
      rx_meta <= RX;
      rxs     <= rx_meta;
      done    <= 1'b0;
      if (load_half)      timer <= (sel_cnt >> 1) - 19'd1;
      else if (load_full) timer <= bit_len - 19'd1;
      else if (!tc)       timer <= timer - 19'd1;
      // Frame configuration is frozen at start detection.
      if (state == IDLE && load_half) begin
        bit_len <= sel_cnt;
        eight_q <= EIGHT;
        pen_q   <= PEN;
        ohel_q  <= OHEL;
        nbit    <= '0;
`ifdef UART_RX_BREAK_EN
        zero_run <= 1'b1;
`endif
      end
      if (state == DATA && tc) begin
        shreg <= {rxs, shreg[7:1]};
        nbit  <= nbit + 4'd1;
`ifdef UART_RX_BREAK_EN
        zero_run <= zero_run & ~rxs;
`endif
      end
      if (state == PARITY && tc) begin
        par_bit <= rxs;
`ifdef UART_RX_BREAK_EN
        zero_run <= zero_run & ~rxs;
`endif
      end
      if (state == STOP && tc) begin
        done      <= 1'b1;
        pend_data <= data_w;
        pend_perr <= pen_q & (par_bit ^ (^data_w) ^ ohel_q);
        pend_ferr <= ~rxs;
        pend_brk  <= brk_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      RX_DATA <= '0;
      RXRDY   <= 1'b0;
      PERR    <= 1'b0;
      FERR    <= 1'b0;
      OVF     <= 1'b0;
      BRK     <= 1'b0;
    end else if (done) begin
      RX_DATA <= pend_data;
      RXRDY   <= 1'b1;
      PERR    <= pend_perr;
      FERR    <= pend_ferr;
      OVF     <= RXRDY & ~CLR;
      BRK     <= pend_brk;
    end else if (CLR) begin
      RXRDY <= 1'b0;
      PERR  <= 1'b0;
      FERR  <= 1'b0;
      OVF   <= 1'b0;
      BRK   <= 1'b0;
    end
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive half of the project UART; the mirror of the existing transmit path.
- Deserializes asynchronous frames on RX using the same control word (EIGHT, PEN, OHEL, BAUD) the transmitter uses.
- Presents the received byte plus status flags to the processor's input port.
- Holds RXRDY until the processor acknowledges with a CLR pulse.

Parameters:
- DIV_SHIFT, 0, right-shift applied to every baud-table count (simulation speed-up; 0 in hardware).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-low reset.
- RX  in  1  serial input, idle high, asynchronous to clk.
- EIGHT  in  1  1 = 8 data bits, 0 = 7 data bits.
- PEN  in  1  1 = parity bit present.
- OHEL  in  1  parity sense: 1 = odd, 0 = even.
- BAUD  in  4  baud select.
- CLR  in  1  one-cycle acknowledge from processor read.
- RX_DATA  out  8  received data, LSB first on the line; bit7 = 0 when EIGHT = 0.
- RXRDY  out  1  frame available.
- PERR  out  1  parity error.
- FERR  out  1  framing error.
- OVF  out  1  overrun.
- BRK  out  1  break detected (see Optional Feature).

Behaviour:
- Reset (rst = 0 at posedge clk):
  - FSM goes to IDLE from any state, including mid-frame.
  - Outputs reset to RX_DATA = 0, RXRDY = 0, PERR = 0, FERR = 0, OVF = 0, BRK = 0.
  - Bit counter and timer reset to 0.
  - Synchronizer flops reset to 1.
- Input synchronization: RX passes through a 2-FF synchronizer. All logic uses the synchronized value rxs.
- Bit time, in clocks, selected by BAUD (0000..1011): 333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217, 109.
  - The selected count is shifted right by DIV_SHIFT.
  - BAUD codes 1100..1111 use 109.
  - BAUD is sampled at start detection and held for the whole frame.
  - Half bit = bit time >> 1.
- Frame length, excluding start: (7 + EIGHT) data bits + PEN parity bit + 1 stop bit.
- FSM states and transitions:
  - IDLE: wait for rxs == 0, then go to START and load timer with half bit.
  - START: at timer expiry, re-check rxs.
    - rxs == 1: false start, return to IDLE with no flag change.
    - rxs == 0: go to DATA and load timer with full bit.
  - DATA: at each expiry (mid-bit), shift rxs into the MSB of the shift register; after 7 or 8 bits go to PARITY if PEN = 1, else STOP.
    - With 7 bits, the register is right-aligned on capture and bit7 is forced to 0.
  - PARITY: sample at mid-bit.
    - Expected parity = XOR of the received data bits, inverted if OHEL = 1.
    - Mismatch sets PERR for this frame.
  - STOP: sample at mid-bit, then return to IDLE without waiting for the end of the stop bit, so back-to-back frames are caught.
    - Stop sample rxs == 0 sets FERR for this frame.
- Completion, one clk after the stop sample:
  - RX_DATA, PERR and FERR are loaded.
  - RXRDY is set to 1.
  - OVF is set to 1 if RXRDY was already 1 and CLR was not asserted that cycle; the old data is overwritten.
- CLR alone clears RXRDY, PERR, FERR, OVF and BRK. RX_DATA holds its value.
- CLR coincident with completion: completion wins. RXRDY = 1, flags reflect the new frame, OVF = 0.
- Control inputs (EIGHT, PEN, OHEL) changing mid-frame take effect at the next start detection only.

Optional Feature:
- Macro: UART_RX_BREAK_EN.
- Defined: BRK is set at completion when all data bits, the parity bit (if present) and the stop bit sampled 0.
  - In that case FERR is also set and RX_DATA = 0.
  - After a break, the FSM stays in IDLE until rxs has been 1 for one full bit time, then re-arms start detection.
  - BRK is cleared by CLR.
- Not defined: BRK is tied to 0, there is no re-arm wait, and a break frame is reported as data 0x00 with FERR = 1.

Test Plan:
- Reset behaviour: rst = 0 for 10 clocks with RX held low -> all outputs 0, no RXRDY after release while RX stays high.
- 8N1 frame: BAUD = 1011, DIV_SHIFT = 0, EIGHT = 1, PEN = 0; send 0x55 at 109 clk/bit -> RXRDY = 1 within 10 bit times of the start edge, RX_DATA = 0x55, PERR = FERR = OVF = 0; then CLR pulse -> RXRDY = 0.
- 7-bit odd parity with bad parity: EIGHT = 0, PEN = 1, OHEL = 1; send 0x41 with parity bit 1 (correct is 1 for odd? 0x41 has 2 ones, so correct is 1) then the same frame with parity bit 0 -> first frame PERR = 0, second frame PERR = 1, RX_DATA = 0x41.
- Framing error and false start:
  - Send 0xA5 with stop bit 0 -> FERR = 1, RX_DATA = 0xA5.
  - Separately, a 30-clock low glitch on RX -> no RXRDY and the FSM back in IDLE.
- Overrun: two back-to-back 0x12 and 0x34 frames with no CLR -> RX_DATA = 0x34, OVF = 1.
  - Repeat with CLR asserted on the second completion cycle -> OVF = 0, RXRDY = 1.
- Mid-frame reset and break:
  - rst = 0 during DATA of a 0xFF frame -> idle state, then the next 0x3C frame is received correctly.
  - With UART_RX_BREAK_EN, hold RX low for 12 bit times -> BRK = 1, FERR = 1, RX_DATA = 0x00, no new frame until RX is high for 1 bit time.
